// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-channel TDM demultiplexer.
//   NCH     : number of time-division channels per frame
//   SLOT_W  : width of the slot index
//   tdm_state_t : HUNT (searching for SYNC) / LOCK (frame-aligned)
package tdm_pkg;

    localparam int unsigned NCH    = 4;
    localparam int unsigned SLOT_W = 2;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } tdm_state_t;

endpackage

// File: rtl/tdm_demux4.sv
// 4-channel time-division demultiplexer. Rebuilds four parallel channels from a
// rotating-slot serial stream aligned by SYNC (marks slot 0).
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   DIN, DIN_VALID     serial sample and its qualifier
//   SYNC               slot-0 marker, only meaningful with DIN_VALID
//   OUT0..OUT3         last complete frame (registered, held between frames)
//   OUT_VALID          1-cycle pulse when OUT0..3 update
//   SLOT               slot index expected for the next valid sample
//   LOCKED             high while frame-aligned
//   ERR                1-cycle pulse on SYNC seen at a non-zero slot
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH      = 1,
    parameter int unsigned MISS_LIMIT = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WIDTH-1:0]  DIN,
    input  logic              DIN_VALID,
    input  logic              SYNC,
    output logic [WIDTH-1:0]  OUT0,
    output logic [WIDTH-1:0]  OUT1,
    output logic [WIDTH-1:0]  OUT2,
    output logic [WIDTH-1:0]  OUT3,
    output logic              OUT_VALID,
    output logic [SLOT_W-1:0] SLOT,
    output logic              LOCKED,
    output logic              ERR
);

    localparam logic [2:0]        MissLimit = 3'(MISS_LIMIT);
    localparam logic [SLOT_W-1:0] LastSlot  = SLOT_W'(NCH - 1);

    tdm_state_t        state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [2:0]        miss_q, miss_d;
    logic [2:0]        miss_inc;
    // The last slot goes straight from DIN to OUT3, so only slots 0..2 need shadowing.
    logic [WIDTH-1:0]  shadow_q [NCH-1];
    logic [WIDTH-1:0]  shadow_d [NCH-1];
    logic [WIDTH-1:0]  out_q    [NCH];
    logic [WIDTH-1:0]  out_d    [NCH];
    logic              out_valid_q, out_valid_d;
    logic              err_q, err_d;

    assign miss_inc = miss_q + 3'd1;

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        miss_d      = miss_q;
        shadow_d    = shadow_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        err_d       = 1'b0;

        if (DIN_VALID) begin
            unique case (state_q)
                HUNT: begin
                    if (SYNC) begin
                        shadow_d[0] = DIN;
                        slot_d      = SLOT_W'(1);
                        miss_d      = 3'd0;
                        state_d     = LOCK;
                    end
                end
                LOCK: begin
                    if (SYNC && (slot_q != '0)) begin
                        // Misaligned SYNC: drop the partial frame and restart at slot 0.
                        err_d       = 1'b1;
                        shadow_d[0] = DIN;
                        slot_d      = SLOT_W'(1);
                        miss_d      = 3'd0;
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                        if (slot_q != LastSlot) begin
                            shadow_d[slot_q] = DIN;
                        end else begin
                            out_d[0]    = shadow_q[0];
                            out_d[1]    = shadow_q[1];
                            out_d[2]    = shadow_q[2];
                            out_d[3]    = DIN;
                            out_valid_d = 1'b1;
                        end
                        if (slot_q == '0) begin
                            if (SYNC) begin
                                miss_d = 3'd0;
                            end else if (miss_inc >= MissLimit) begin
                                // Sample is accepted but lock is abandoned.
                                miss_d  = 3'd0;
                                slot_d  = '0;
                                state_d = HUNT;
                            end else begin
                                miss_d = miss_inc;
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= HUNT;
            slot_q      <= '0;
            miss_q      <= 3'd0;
            shadow_q    <= '{default: '0};
            out_q       <= '{default: '0};
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            miss_q      <= miss_d;
            shadow_q    <= shadow_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign OUT0      = out_q[0];
    assign OUT1      = out_q[1];
    assign OUT2      = out_q[2];
    assign OUT3      = out_q[3];
    assign OUT_VALID = out_valid_q;
    assign SLOT      = slot_q;
    assign LOCKED    = (state_q == LOCK);
    assign ERR       = err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4 (WIDTH=4, MISS_LIMIT=2). The driver pushes
// expected frames and expected ERR pulses; a monitor pops/compares at negedge.
module tb_tdm_demux4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] DIN = '0;
    logic       DIN_VALID = 1'b0;
    logic       SYNC = 1'b0;
    logic [3:0] OUT0, OUT1, OUT2, OUT3;
    logic       OUT_VALID;
    logic [1:0] SLOT;
    logic       LOCKED;
    logic       ERR;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q [$];
    int          err_exp = 0;
    logic [15:0] cur_out = '0;
    logic        rst_s;

    tdm_demux4 #(
        .WIDTH      (4),
        .MISS_LIMIT (2)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .DIN       (DIN),
        .DIN_VALID (DIN_VALID),
        .SYNC      (SYNC),
        .OUT0      (OUT0),
        .OUT1      (OUT1),
        .OUT2      (OUT2),
        .OUT3      (OUT3),
        .OUT_VALID (OUT_VALID),
        .SLOT      (SLOT),
        .LOCKED    (LOCKED),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One valid sample; returns 1 time unit after the capturing edge.
    task automatic smp(input logic [3:0] d, input logic s);
        DIN = d;
        SYNC = s;
        DIN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        DIN_VALID = 1'b0;
        SYNC = 1'b0;
    endtask

    task automatic idle(input int n, input logic s);
        SYNC = s;
        DIN = 4'hf;
        DIN_VALID = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
        SYNC = 1'b0;
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
        exp_q.push_back({a, b, c, d});
    endtask

    // Monitor: checks every frame update against the scoreboard and that
    // outputs never move without OUT_VALID.
    initial begin
        logic [15:0] e;
        forever begin
            @(posedge CLK);
            rst_s = RST;
            @(negedge CLK);
            if (rst_s) begin
                cur_out = '0;
                chk("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
                chk("rst_err", {31'd0, ERR}, 32'd0);
            end else begin
                if (OUT_VALID) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out_valid: got %h expected none at %0t",
                                 {OUT0, OUT1, OUT2, OUT3}, $time);
                    end else begin
                        e = exp_q.pop_front();
                        cur_out = e;
                    end
                end
                if (ERR) begin
                    checks++;
                    if (err_exp == 0) begin
                        errors++;
                        $display("FAIL unexpected_err: got 1 expected 0 at %0t", $time);
                    end else begin
                        err_exp--;
                    end
                end
            end
            chk("out_frame", {16'd0, OUT0, OUT1, OUT2, OUT3}, {16'd0, cur_out});
        end
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("reset_locked", {31'd0, LOCKED}, 32'd0);
        chk("reset_slot", {30'd0, SLOT}, 32'd0);
        chk("reset_out", {16'd0, OUT0, OUT1, OUT2, OUT3}, 32'd0);
        chk("reset_out_valid", {31'd0, OUT_VALID}, 32'd0);

        // 1: back-to-back frame 1,0,1,1
        smp(4'h1, 1'b1);
        chk("t1_locked", {31'd0, LOCKED}, 32'd1);
        chk("t1_slot", {30'd0, SLOT}, 32'd1);
        smp(4'h0, 1'b0);
        smp(4'h1, 1'b0);
        push(4'h1, 4'h0, 4'h1, 4'h1);
        smp(4'h1, 1'b0);
        chk("t1_out_valid", {31'd0, OUT_VALID}, 32'd1);
        chk("t1_slot_wrap", {30'd0, SLOT}, 32'd0);

        // 2: sparse frames with idles; SYNC during idle in LOCK must be ignored
        smp(4'h1, 1'b1);
        idle(2, 1'b0);
        chk("t2_slot_hold", {30'd0, SLOT}, 32'd1);
        smp(4'h2, 1'b0);
        idle(2, 1'b0);
        smp(4'h3, 1'b0);
        idle(2, 1'b0);
        push(4'h1, 4'h2, 4'h3, 4'h4);
        smp(4'h4, 1'b0);
        idle(2, 1'b0);
        smp(4'h5, 1'b1);
        idle(2, 1'b1);
        chk("t6_lock_slot", {30'd0, SLOT}, 32'd1);
        chk("t6_lock_locked", {31'd0, LOCKED}, 32'd1);
        smp(4'h6, 1'b0);
        idle(2, 1'b0);
        smp(4'h7, 1'b0);
        idle(2, 1'b0);
        push(4'h5, 4'h6, 4'h7, 4'h8);
        smp(4'h8, 1'b0);
        idle(2, 1'b0);
        chk("t2_final_out", {16'd0, OUT0, OUT1, OUT2, OUT3}, 32'h5678);

        // 3: SYNC on the 3rd sample of a frame
        smp(4'ha, 1'b1);
        smp(4'hb, 1'b0);
        err_exp++;
        smp(4'hc, 1'b1);
        chk("t3_err", {31'd0, ERR}, 32'd1);
        chk("t3_slot", {30'd0, SLOT}, 32'd1);
        chk("t3_no_valid", {31'd0, OUT_VALID}, 32'd0);
        smp(4'hd, 1'b0);
        smp(4'he, 1'b0);
        push(4'hc, 4'hd, 4'he, 4'hf);
        smp(4'hf, 1'b0);

        // 4: SYNC withheld; first miss still emits, second drops lock
        push(4'h1, 4'h2, 4'h3, 4'h4);
        smp(4'h1, 1'b0);
        chk("t4_still_locked", {31'd0, LOCKED}, 32'd1);
        smp(4'h2, 1'b0);
        smp(4'h3, 1'b0);
        smp(4'h4, 1'b0);
        smp(4'h9, 1'b0);
        chk("t4_unlocked", {31'd0, LOCKED}, 32'd0);
        chk("t4_slot", {30'd0, SLOT}, 32'd0);
        smp(4'h5, 1'b0);
        smp(4'h6, 1'b0);
        chk("t4_hunt_slot", {30'd0, SLOT}, 32'd0);
        chk("t4_hunt_locked", {31'd0, LOCKED}, 32'd0);

        // 5: reset after slot 2 of a frame
        smp(4'h7, 1'b1);
        chk("t5_relocked", {31'd0, LOCKED}, 32'd1);
        smp(4'h8, 1'b0);
        smp(4'h9, 1'b0);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("t5_out", {16'd0, OUT0, OUT1, OUT2, OUT3}, 32'd0);
        chk("t5_locked", {31'd0, LOCKED}, 32'd0);
        chk("t5_slot", {30'd0, SLOT}, 32'd0);
        smp(4'h2, 1'b0);
        chk("t5_hunt_drop", {31'd0, LOCKED}, 32'd0);

        // 6: SYNC without DIN_VALID in HUNT
        idle(3, 1'b1);
        chk("t6_hunt_locked", {31'd0, LOCKED}, 32'd0);
        chk("t6_hunt_slot", {30'd0, SLOT}, 32'd0);

        // Fresh frame after reset
        smp(4'h1, 1'b1);
        smp(4'h2, 1'b0);
        smp(4'h3, 1'b0);
        push(4'h1, 4'h2, 4'h3, 4'h4);
        smp(4'h4, 1'b0);
        idle(3, 1'b0);

        chk("pending_frames", exp_q.size(), 32'd0);
        chk("pending_errs", err_exp, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
